// File: rtl/timeout_scheduler.sv
// timeout_scheduler: round-robin sharing of one interval timer among N_REQ one-shot timeout requesters
// Ports:
//   clk, reset_n                    clock and asynchronous active-low reset, shared with the timer
//   req, req_period                 level requests and per-requester 32-bit periods (sampled at grant)
//   ack, ack_cancelled              one-cycle completion pulse and its cancelled/expired flag
//   busy, active_id                 scheduler activity and index of the granted requester
//   tmr_address .. tmr_writedata    write-only master port to the timer registers
//   tmr_irq                         timer interrupt
module timeout_scheduler #(
    parameter int N_REQ = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [32*N_REQ-1:0]    req_period,
    output logic [N_REQ-1:0]       ack,
    output logic                   ack_cancelled,
    output logic                   busy,
    output logic [2:0]             active_id,
    output logic [2:0]             tmr_address,
    output logic                   tmr_chipselect,
    output logic                   tmr_write_n,
    output logic [15:0]            tmr_writedata,
    input  logic                   tmr_irq
);
    typedef enum logic [3:0] {IDLE, ARB, WR_PL, WR_PH, SETTLE, WR_CTRL, WAIT, WR_STOP, WR_STAT, ACK} state_t;
    state_t state_q, state_d;
    logic [2:0] ptr_q, ptr_d, id_q, id_d, win, idx;
    logic [31:0] load_q, load_d, win_period;
    logic [3:0] s;
    logic cancel_q, cancel_d, found, own;
    logic [N_REQ-1:0] ack_d;
    logic ack_cancelled_d, busy_d, cs_d;
    logic [2:0] addr_d;
    logic [15:0] data_d;
    // first pending request at or after the pointer, wrapping modulo N_REQ
    always_comb begin
        found = 1'b0;
        win = '0;
        s = '0;
        idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            s = {1'b0, ptr_q} + 4'(k);
            idx = (s >= 4'(N_REQ)) ? 3'(s - 4'(N_REQ)) : s[2:0];
            if (!found && 1'(req >> idx)) begin
                found = 1'b1;
                win = idx;
            end
        end
        win_period = 32'(req_period >> {win, 5'd0});
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q <= '0;
            id_q <= '0;
            load_q <= '0;
            cancel_q <= 1'b0;
            ack <= '0;
            ack_cancelled <= 1'b0;
            busy <= 1'b0;
            tmr_chipselect <= 1'b0;
            tmr_write_n <= 1'b1;
            tmr_address <= '0;
            tmr_writedata <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            id_q <= id_d;
            load_q <= load_d;
            cancel_q <= cancel_d;
            ack <= ack_d;
            ack_cancelled <= ack_cancelled_d;
            busy <= busy_d;
            tmr_chipselect <= cs_d;
            tmr_write_n <= ~cs_d;
            tmr_address <= addr_d;
            tmr_writedata <= data_d;
        end
    end
    assign active_id = id_q;
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        id_d = id_q;
        load_d = load_q;
        cancel_d = cancel_q;
        own = |(req & (N_REQ'(1) << id_q));
        case (state_q)
            IDLE: state_d = (|req) ? ARB : IDLE;
            ARB: begin
                state_d = found ? WR_PL : IDLE;
                if (found) begin
                    id_d = win;
                    ptr_d = (win == 3'(N_REQ - 1)) ? 3'd0 : win + 3'd1;
                    load_d = (win_period < 32'd2) ? 32'd1 : win_period - 32'd1;
                end
            end
            WR_PL: state_d = WR_PH;
            WR_PH: state_d = SETTLE;
            SETTLE: state_d = WR_CTRL;
            WR_CTRL: state_d = WAIT;
            // a dropped request takes priority over a coincident interrupt
            WAIT: begin
                state_d = !own ? WR_STOP : tmr_irq ? WR_STAT : WAIT;
                cancel_d = cancel_q | !own;
            end
            WR_STOP: state_d = WR_STAT;
            WR_STAT: state_d = ACK;
            ACK: begin
                state_d = IDLE;
                cancel_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    // outputs are decoded from the next state so they line up with it once registered
    always_comb begin
        cs_d = state_d inside {WR_PL, WR_PH, WR_CTRL, WR_STOP, WR_STAT};
        addr_d = (state_d == WR_PL) ? 3'd2 :
                 (state_d == WR_PH) ? 3'd3 :
                 (state_d == WR_CTRL || state_d == WR_STOP) ? 3'd1 : 3'd0;
        data_d = (state_d == WR_PL) ? load_d[15:0] :
                 (state_d == WR_PH) ? load_d[31:16] :
                 (state_d == WR_CTRL) ? 16'h0005 :
                 (state_d == WR_STOP) ? 16'h0008 : 16'h0000;
        ack_d = (state_d == ACK) ? (N_REQ'(1) << id_d) : '0;
        ack_cancelled_d = (state_d == ACK) && cancel_d;
        busy_d = state_d != IDLE;
    end
endmodule

// File: tb/tb_timeout_scheduler.sv
// tb_timeout_scheduler: scoreboard bench for timeout_scheduler with a behavioural companion timer
module tb_timeout_scheduler;
    localparam int N = 4;
    logic clk = 1'b0, reset_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [32*N-1:0] req_period = '0;
    logic [N-1:0] ack;
    logic ack_cancelled, busy, tmr_chipselect, tmr_write_n, tmr_irq;
    logic [2:0] active_id, tmr_address;
    logic [15:0] tmr_writedata;
    logic irq_m, run_m, irq_force = 1'b0;
    logic [31:0] ld_m, cnt_m;
    int cyc = 0, checks = 0, passes = 0;
    typedef struct {int cyc; logic wn; logic [2:0] a; logic [15:0] d;} wr_t;
    typedef struct {int cyc; logic [N-1:0] v; logic c;} ak_t;
    wr_t wr_q[$];
    ak_t ak_q[$];
    logic [18:0] exp_wr[$];
    logic [N:0] exp_ak[$];
    wr_t mw;
    ak_t mk;

    timeout_scheduler #(.N_REQ(N)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_period(req_period),
        .ack(ack), .ack_cancelled(ack_cancelled), .busy(busy), .active_id(active_id),
        .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
        .tmr_writedata(tmr_writedata), .tmr_irq(tmr_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign tmr_irq = irq_m | irq_force;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_m <= 1'b0; run_m <= 1'b0; ld_m <= '0; cnt_m <= '0;
        end else begin
            if (run_m) begin
                if (cnt_m == 0) begin irq_m <= 1'b1; run_m <= 1'b0; end
                else cnt_m <= cnt_m - 1;
            end
            if (tmr_chipselect && !tmr_write_n) begin
                case (tmr_address)
                    3'd0: irq_m <= 1'b0;
                    3'd1: begin
                        if (tmr_writedata[2]) begin run_m <= 1'b1; cnt_m <= ld_m; end
                        if (tmr_writedata[3]) run_m <= 1'b0;
                    end
                    3'd2: begin ld_m[15:0] <= tmr_writedata; run_m <= 1'b0; end
                    3'd3: begin ld_m[31:16] <= tmr_writedata; run_m <= 1'b0; end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) if (reset_n) begin
        if (tmr_chipselect) begin
            mw.cyc = cyc; mw.wn = tmr_write_n; mw.a = tmr_address; mw.d = tmr_writedata;
            wr_q.push_back(mw);
        end
        if (|ack) begin
            mk.cyc = cyc; mk.v = ack; mk.c = ack_cancelled;
            ak_q.push_back(mk);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; req = '0; irq_force = 1'b0;
        tick(2);
        reset_n = 1'b1;
        wr_q.delete(); ak_q.delete(); exp_wr.delete(); exp_ak.delete();
    endtask

    task automatic push_txn(input logic [15:0] lo, input logic [15:0] hi, input logic cx);
        exp_wr.push_back({3'd2, lo});
        exp_wr.push_back({3'd3, hi});
        exp_wr.push_back({3'd1, 16'h0005});
        if (cx) exp_wr.push_back({3'd1, 16'h0008});
        exp_wr.push_back({3'd0, 16'h0000});
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(2);
        checks++;
        if ({ack, ack_cancelled, busy, active_id, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 16'h0})
            $display("FAIL reset_in: got ack=%b c=%b busy=%b id=%0d cs=%b wn=%b a=%0d d=%h, want all idle", ack, ack_cancelled, busy, active_id, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
        else passes++;
        apply_reset();
        tick(3);
        checks++;
        if ({ack, busy, tmr_chipselect, tmr_write_n} !== {4'h0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_idle: got ack=%b busy=%b cs=%b wn=%b, want 0 0 0 1", ack, busy, tmr_chipselect, tmr_write_n);
        else passes++;
    endtask

    task automatic test_single();
        int r, c;
        wr_t w;
        ak_t k;
        logic [18:0] e;
        wr_q.delete(); ak_q.delete();
        push_txn(16'h0063, 16'h0000, 1'b0);
        exp_ak.push_back({4'b0010, 1'b0});
        req_period[63:32] = 32'd100;
        r = cyc; c = 0;
        req[1] = 1'b1;
        tick(30);
        checks++;
        if ({busy, active_id} !== {1'b1, 3'd1}) $display("FAIL single_busy: got busy=%b id=%0d, want 1 1", busy, active_id);
        else passes++;
        for (int i = 0; i < 300 && ak_q.size() == 0; i++) tick(1);
        req[1] = 1'b0;
        checks++;
        if (wr_q.size() == 0 || wr_q[0].cyc - r != 2) $display("FAIL single_latency: got first write %0d cycles after req, want 2", wr_q.size() ? wr_q[0].cyc - r : -1);
        else passes++;
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            checks++;
            if (wr_q.size() == 0) $display("FAIL single_wr: got none, want a=%0d d=%h", e[18:16], e[15:0]);
            else begin
                w = wr_q.pop_front();
                if (e == {3'd1, 16'h0005}) c = w.cyc;
                if ({w.wn, w.a, w.d} !== {1'b0, e}) $display("FAIL single_wr: got wn=%b a=%0d d=%h, want wn=0 a=%0d d=%h", w.wn, w.a, w.d, e[18:16], e[15:0]);
                else passes++;
            end
        end
        checks++;
        if (ak_q.size() == 0) $display("FAIL single_ack: got no ack within budget, want ack=0010");
        else begin
            k = ak_q.pop_front();
            e = 19'(exp_ak.pop_front());
            if ({k.v, k.c} !== e[N:0]) $display("FAIL single_ack: got ack=%b c=%b, want %b", k.v, k.c, e[N:0]);
            else passes++;
            checks++;
            if (k.cyc - c != 103) $display("FAIL single_ack_time: got %0d cycles after WR_CTRL, want 103", k.cyc - c);
            else passes++;
        end
    endtask

    task automatic test_round_robin();
        ak_t k;
        logic [N:0] e;
        apply_reset();
        for (int i = 0; i < N; i++) req_period[32*i +: 32] = 32'd10;
        exp_ak.push_back({4'b0001, 1'b0});
        exp_ak.push_back({4'b0010, 1'b0});
        exp_ak.push_back({4'b0100, 1'b0});
        exp_ak.push_back({4'b1000, 1'b0});
        exp_ak.push_back({4'b0001, 1'b0});
        req = 4'hF;
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 100 && ak_q.size() == 0; i++) tick(1);
            checks++;
            if (ak_q.size() == 0) $display("FAIL rr_ack%0d: got no ack within budget, want one", n);
            else begin
                k = ak_q.pop_front();
                e = exp_ak.pop_front();
                if ({k.v, k.c} !== e) $display("FAIL rr_ack%0d: got ack=%b c=%b, want %b", n, k.v, k.c, e);
                else passes++;
                req = req & ~k.v;
                wr_q.delete();
                if (n < 4) begin
                    for (int i = 0; i < 20 && wr_q.size() == 0; i++) tick(1);
                    checks++;
                    if (wr_q.size() == 0) $display("FAIL rr_gap%0d: got no WR_PL, want one 3 cycles after ack", n);
                    else if (wr_q[0].cyc - k.cyc != 3 || wr_q[0].a !== 3'd2) $display("FAIL rr_gap%0d: got a=%0d %0d cycles after ack, want a=2 after 3", n, wr_q[0].a, wr_q[0].cyc - k.cyc);
                    else passes++;
                end
                if (n == 0) req[0] = 1'b1;
            end
        end
    endtask

    task automatic test_period_edges();
        logic [31:0] pers [3] = '{32'h0001_0000, 32'd0, 32'd1};
        logic [15:0] los [3] = '{16'hFFFF, 16'h0001, 16'h0001};
        wr_t w;
        ak_t k;
        logic [18:0] e;
        logic [N:0] ea;
        int c;
        logic cx;
        for (int t = 0; t < 3; t++) begin
            wr_q.delete(); ak_q.delete();
            cx = (t == 0);
            c = 0;
            push_txn(los[t], 16'h0000, cx);
            exp_ak.push_back({4'b1000, cx});
            req_period[127:96] = pers[t];
            req[3] = 1'b1;
            for (int i = 0; i < 20 && wr_q.size() < 3; i++) tick(1);
            if (cx) begin tick(5); req[3] = 1'b0; end
            for (int i = 0; i < 50 && ak_q.size() == 0; i++) tick(1);
            req[3] = 1'b0;
            while (exp_wr.size() > 0) begin
                e = exp_wr.pop_front();
                checks++;
                if (wr_q.size() == 0) $display("FAIL edge%0d_wr: got none, want a=%0d d=%h", t, e[18:16], e[15:0]);
                else begin
                    w = wr_q.pop_front();
                    if (e == {3'd1, 16'h0005}) c = w.cyc;
                    if ({w.wn, w.a, w.d} !== {1'b0, e}) $display("FAIL edge%0d_wr: got wn=%b a=%0d d=%h, want wn=0 a=%0d d=%h", t, w.wn, w.a, w.d, e[18:16], e[15:0]);
                    else passes++;
                end
            end
            checks++;
            if (ak_q.size() == 0) $display("FAIL edge%0d_ack: got no ack within budget, want one", t);
            else begin
                k = ak_q.pop_front();
                ea = exp_ak.pop_front();
                if ({k.v, k.c} !== ea) $display("FAIL edge%0d_ack: got ack=%b c=%b, want %b", t, k.v, k.c, ea);
                else passes++;
                if (!cx) begin
                    checks++;
                    if (k.cyc - c != 5) $display("FAIL edge%0d_ack_time: got %0d cycles after WR_CTRL, want 5", t, k.cyc - c);
                    else passes++;
                end
            end
        end
    endtask

    task automatic test_cancel(input int bit_i, input int period, input int into_wait, input logic [15:0] lo);
        wr_t w;
        ak_t k;
        logic [18:0] e;
        logic [N:0] ea;
        int c, wc, stop_c, stat_c;
        wr_q.delete(); ak_q.delete(); exp_wr.delete(); exp_ak.delete();
        stop_c = 0; stat_c = 0;
        push_txn(lo, 16'h0000, 1'b1);
        exp_ak.push_back({N'(1) << bit_i, 1'b1});
        req_period[32*bit_i +: 32] = period;
        req[bit_i] = 1'b1;
        for (int i = 0; i < 20 && wr_q.size() < 3; i++) tick(1);
        c = (wr_q.size() >= 3) ? wr_q[2].cyc : cyc;
        wc = c + 1 + into_wait;
        for (int i = 0; i < 2000 && cyc < wc; i++) tick(1);
        if (into_wait > 40) begin
            checks++;
            if (tmr_irq !== 1'b1) $display("FAIL cancel%0d_irq: got tmr_irq=%b at drop, want 1", bit_i, tmr_irq);
            else passes++;
        end
        req[bit_i] = 1'b0;
        for (int i = 0; i < 20 && ak_q.size() == 0; i++) tick(1);
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            checks++;
            if (wr_q.size() == 0) $display("FAIL cancel%0d_wr: got none, want a=%0d d=%h", bit_i, e[18:16], e[15:0]);
            else begin
                w = wr_q.pop_front();
                if (e == {3'd1, 16'h0008}) stop_c = w.cyc;
                if (e == {3'd0, 16'h0000}) stat_c = w.cyc;
                if ({w.wn, w.a, w.d} !== {1'b0, e}) $display("FAIL cancel%0d_wr: got wn=%b a=%0d d=%h, want wn=0 a=%0d d=%h", bit_i, w.wn, w.a, w.d, e[18:16], e[15:0]);
                else passes++;
            end
        end
        checks++;
        if (stop_c - wc != 1 || stat_c - wc != 2) $display("FAIL cancel%0d_seq: got STOP at w+%0d STAT at w+%0d, want w+1 w+2", bit_i, stop_c - wc, stat_c - wc);
        else passes++;
        checks++;
        if (ak_q.size() == 0) $display("FAIL cancel%0d_ack: got no ack within budget, want one", bit_i);
        else begin
            k = ak_q.pop_front();
            ea = exp_ak.pop_front();
            if ({k.v, k.c} !== ea || k.cyc - wc != 3) $display("FAIL cancel%0d_ack: got ack=%b c=%b at w+%0d, want %b at w+3", bit_i, k.v, k.c, k.cyc - wc, ea);
            else passes++;
        end
    endtask

    task automatic test_no_spurious();
        tick(1100);
        checks++;
        if (ak_q.size() != 0 || wr_q.size() != 0) $display("FAIL no_spurious: got %0d acks %0d writes after cancel, want 0 0", ak_q.size(), wr_q.size());
        else passes++;
    endtask

    task automatic test_irq_idle();
        wr_q.delete(); ak_q.delete();
        irq_force = 1'b1;
        tick(10);
        checks++;
        if (busy !== 1'b0 || wr_q.size() != 0 || ak_q.size() != 0) $display("FAIL irq_idle: got busy=%b writes=%0d acks=%0d, want 0 0 0", busy, wr_q.size(), ak_q.size());
        else passes++;
        irq_force = 1'b0;
        tick(2);
    endtask

    task automatic test_reset_mid();
        ak_t k;
        logic [N:0] ea;
        wr_q.delete(); ak_q.delete(); exp_ak.delete();
        req_period[63:32] = 32'd1000;
        req[1] = 1'b1;
        for (int i = 0; i < 20 && wr_q.size() < 3; i++) tick(1);
        tick(5);
        checks++;
        if ({busy, active_id} !== {1'b1, 3'd1}) $display("FAIL mid_wait: got busy=%b id=%0d, want 1 1", busy, active_id);
        else passes++;
        reset_n = 1'b0;
        req = '0;
        #1;
        checks++;
        if ({ack, ack_cancelled, busy, active_id, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 16'h0})
            $display("FAIL mid_reset: got ack=%b c=%b busy=%b id=%0d cs=%b wn=%b a=%0d d=%h, want all idle", ack, ack_cancelled, busy, active_id, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
        else passes++;
        tick(2);
        reset_n = 1'b1;
        wr_q.delete(); ak_q.delete();
        req_period[31:0] = 32'd10;
        req_period[127:96] = 32'd10;
        exp_ak.push_back({4'b0001, 1'b0});
        exp_ak.push_back({4'b1000, 1'b0});
        req = 4'b1001;
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 100 && ak_q.size() == 0; i++) tick(1);
            checks++;
            if (ak_q.size() == 0) $display("FAIL mid_grant%0d: got no ack within budget, want one", n);
            else begin
                k = ak_q.pop_front();
                ea = exp_ak.pop_front();
                if ({k.v, k.c} !== ea) $display("FAIL mid_grant%0d: got ack=%b c=%b, want %b", n, k.v, k.c, ea);
                else passes++;
                req = req & ~k.v;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_period_edges();
        test_cancel(2, 1000, 20, 16'h03E7);
        test_no_spurious();
        test_cancel(0, 50, 50, 16'h0031);
        test_irq_idle();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/timeout_scheduler.md
# timeout_scheduler

Shares the single 32-bit interval timer (16-bit register-mapped slave) among `N_REQ` hardware requesters that each need a one-shot timeout. The block arbitrates pending requests round-robin and programs the timer over its register port. It waits for the timer IRQ, clears the timer status, and acknowledges the winning requester. It sits between requester logic and the timer slave, and is the only master on the timer's register port.

## Interface
- `N_REQ`, default 4: number of requesters, legal range 1..8.
- `clk` in 1: clock, shared with the timer.
- `reset_n` in 1: asynchronous, active-low reset, shared with the timer.
- `req` in N_REQ: level request per requester. It is held high until `ack`; dropping it early means cancel.
- `req_period` in 32*N_REQ: timeout length in clk ticks. Slice i is `[32*i+31:32*i]`. It is sampled only at grant.
- `ack` out N_REQ: one-cycle pulse, at most one bit set at a time.
- `ack_cancelled` out 1: valid with `ack`. 1 means the timeout was cancelled; 0 means it expired.
- `busy` out 1: high in every state except IDLE.
- `active_id` out 3: index of the granted requester. Valid while `busy`.
- `tmr_address` out 3: timer register address.
- `tmr_chipselect` out 1: timer chip select.
- `tmr_write_n` out 1: timer write strobe, active low.
- `tmr_writedata` out 16: timer write data.
- `tmr_irq` in 1: timer interrupt.

## Operation
- Timer register map:
  - 0: status. Any write clears the timeout flag.
  - 1: control. Bit0 = interrupt enable, bit1 = continuous, bit2 = START, bit3 = STOP.
  - 2: period low half.
  - 3: period high half.
  - Writing a period register stops the timer and forces a reload on the following cycle.
- Register writes:
  - Each write is one cycle with `tmr_chipselect=1` and `tmr_write_n=0`.
  - Outside writes, `tmr_chipselect=0`, `tmr_write_n=1`, `tmr_address=0` and `tmr_writedata=0`.
  - The block never reads the timer.
- Programmed load value: L = max(`req_period`, 2) − 1. Periods 0 and 1 are therefore treated as 2.
- Round-robin arbitration:
  - A 3-bit pointer resets to 0.
  - The search starts at the pointer index and wraps modulo `N_REQ`.
  - After granting index g, the pointer becomes g+1 (mod `N_REQ`).
- FSM states, one state per cycle unless noted:
  - IDLE: if any `req` is high, go to ARB.
  - ARB: pick the winner, latch `active_id` and L, go to WR_PL. If no `req` is still high, return to IDLE.
  - WR_PL: write L[15:0] to address 2.
  - WR_PH: write L[31:16] to address 3.
  - SETTLE: one idle cycle so the timer's forced reload completes.
  - WR_CTRL: write 0x0005 (interrupt enable + START, one-shot) to address 1.
  - WAIT: stays here until `tmr_irq`, then goes to WR_STAT. If `req[active_id]` is low, go to WR_STOP instead; cancel wins when `tmr_irq` and the dropped `req` occur in the same cycle.
  - WR_STOP: write 0x0008 (STOP, interrupt disabled) to address 1, then go to WR_STAT with the cancel flag set.
  - WR_STAT: write 0x0000 to address 0.
  - ACK: pulse `ack[active_id]`, drive `ack_cancelled` = cancel flag, clear the cancel flag, go to IDLE.
- A `req` drop during ARB..WR_CTRL is detected only in WAIT. It still completes through the cancel path and is acknowledged with `ack_cancelled=1`.
- `tmr_irq` is ignored in every state except WAIT.
- Reset mid-operation: the FSM returns to IDLE and all outputs go to their reset values. The timer is reset by the same `reset_n`, so no cleanup writes are issued.

## Timing
- Reset values:
  - `ack`=0, `ack_cancelled`=0, `busy`=0, `active_id`=0.
  - `tmr_chipselect`=0, `tmr_write_n`=1, `tmr_address`=0, `tmr_writedata`=0.
  - FSM in IDLE, pointer=0, cancel flag=0.
- All outputs are registered.
- Request to first timer write: `req` rising at cycle r puts ARB in r+1 and WR_PL in r+2.
- With cycle c = WR_CTRL and the companion timer: `tmr_irq` rises at c+L+2, WR_STAT occurs at c+L+3, and `ack` pulses at c+L+4.
- Back-to-back requests: the cycle after ACK is IDLE, and the next ARB follows one cycle later. Minimum gap from `ack` to the next WR_PL is 3 cycles.
- Cancel: the drop is detected in WAIT cycle w. WR_STOP is at w+1, WR_STAT at w+2, and `ack` with `ack_cancelled=1` at w+3.

## Test plan
- N_REQ=4, `req[1]` only, period 100 → writes 99 (0x0063) to address 2, 0 to address 3, 0x0005 to address 1; `ack[1]` 103 cycles after WR_CTRL; `ack_cancelled`=0.
- `req[0]` through `req[3]` all high from reset, period 10 each, each requester drops its `req` after its `ack` → grants in order 0,1,2,3; `req[0]` re-raised after its `ack` is granted only after 3.
- Period 0x0001_0000 → address 2 gets 0xFFFF and address 3 gets 0x0000. Periods 0 and 1 → L=1.
- `req[2]` dropped 20 cycles into WAIT with period 1000 → 0x0008 written to address 1, then status cleared, then `ack[2]` with `ack_cancelled=1` at w+3; no later spurious `ack`.
- `tmr_irq` and the `req` drop in the same WAIT cycle → cancel path taken with `ack_cancelled=1`. `tmr_irq` forced high while in IDLE → no effect.
- `reset_n` asserted during WAIT → all outputs return to reset values asynchronously; after release, the next grant starts at index 0.
